// File: rtl/sqlite_rec_pkg.sv
// Shared types for the transaction recorder: record ops, capture kinds,
// the default record layout and the sequencer states.
package sqlite_rec_pkg;

  typedef enum logic [1:0] {
    OP_BEGIN  = 2'd0,
    OP_ROW    = 2'd1,
    OP_COMMIT = 2'd2
  } op_e;

  typedef enum logic [1:0] {
    KIND_READ  = 2'd0,
    KIND_WRITE = 2'd1,
    KIND_OTHER = 2'd2,
    KIND_RSVD  = 2'd3
  } kind_e;

  localparam int REC_ADDR_W = 32;
  localparam int REC_DATA_W = 32;
  localparam int REC_TS_W   = 32;

  // Logger-side record layout at the default widths.
  typedef struct packed {
    kind_e                 kind;
    logic [REC_ADDR_W-1:0] addr;
    logic [REC_DATA_W-1:0] data;
    logic [REC_TS_W-1:0]   ts;
  } rec_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BEGIN  = 2'd1,
    ST_ROW    = 2'd2,
    ST_COMMIT = 2'd3
  } state_e;

endpackage

// File: rtl/sqlite_txn_recorder_if.sv
// Capture/record bundle of the transaction recorder; master is the
// monitor+logger side, slave is the recorder side.
interface sqlite_txn_recorder_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TS_W   = 32,
  parameter int LVL_W  = 5
);
  logic              in_valid;
  logic [1:0]        in_kind;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        out_op;
  logic [1:0]        out_kind;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;
  logic [TS_W-1:0]   out_ts;
  logic [LVL_W-1:0]  fifo_level;
  logic [15:0]       drop_cnt;

  modport master (
    output in_valid, in_kind, in_addr, in_data, flush, out_ready,
    input  out_valid, out_op, out_kind, out_addr, out_data, out_ts,
           fifo_level, drop_cnt
  );

  modport slave (
    input  in_valid, in_kind, in_addr, in_data, flush, out_ready,
    output out_valid, out_op, out_kind, out_addr, out_data, out_ts,
           fifo_level, drop_cnt
  );
endinterface

// File: rtl/sqlite_rec_fifo.sv
// Synchronous record FIFO with occupancy output; writes to a full FIFO
// and reads from an empty one are ignored.
module sqlite_rec_fifo #(
  parameter int WIDTH = 98,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d;
  logic [LW-1:0]    lvl_q, lvl_d;
  logic             do_wr, do_rd;

  assign empty   = (lvl_q == '0);
  assign full    = (lvl_q == LW'(DEPTH));
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rp_q];
  assign level   = lvl_q;

  always_comb begin
    wp_d  = do_wr ? wp_q + AW'(1) : wp_q;
    rp_d  = do_rd ? rp_q + AW'(1) : rp_q;
    lvl_d = lvl_q;
    case ({do_wr, do_rd})
      2'b10:   lvl_d = lvl_q + LW'(1);
      2'b01:   lvl_d = lvl_q - LW'(1);
      default: lvl_d = lvl_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      lvl_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      lvl_q <= lvl_d;
    end
  end

  // Storage needs no reset: the level gates every read.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wp_q] <= wr_data;
  end

endmodule

// File: rtl/sqlite_txn_recorder.sv
// Timestamps monitor captures, buffers them and emits them to the logger
// as BEGIN / 1..BATCH ROW / COMMIT groups.
module sqlite_txn_recorder
  import sqlite_rec_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TS_W    = 32,
  parameter int DEPTH   = 16,
  parameter int BATCH   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [1:0]             in_kind,
  input  logic [ADDR_W-1:0]      in_addr,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [1:0]             out_op,
  output logic [1:0]             out_kind,
  output logic [ADDR_W-1:0]      out_addr,
  output logic [DATA_W-1:0]      out_data,
  output logic [TS_W-1:0]        out_ts,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [15:0]            drop_cnt
);
  localparam int BC_W = $clog2(BATCH + 1);
  localparam int GC_W = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic [1:0]        kind;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [TS_W-1:0]   ts;
  } row_t;

  state_e          state_q, state_d;
  logic [TS_W-1:0] ts_q, ts_d;
  logic [15:0]     drop_q, drop_d;
  logic [BC_W-1:0] batch_q, batch_d;
  logic [GC_W-1:0] gap_q, gap_d;

  row_t cap_row, head;
  logic fifo_empty, fifo_full, pop;
  op_e  op;

  assign cap_row = '{kind: in_kind, addr: in_addr, data: in_data, ts: ts_q};
  assign pop     = (state_q == ST_ROW) && !fifo_empty && out_ready;

  sqlite_rec_fifo #(.WIDTH($bits(row_t)), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (in_valid),
    .wr_data (cap_row),
    .rd_en   (pop),
    .rd_data (head),
    .level   (fifo_level),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  always_comb begin
    ts_d    = ts_q + TS_W'(1);
    drop_d  = drop_q;
    if (in_valid && fifo_full && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
    state_d = state_q;
    batch_d = batch_q;
    gap_d   = gap_q;
    unique case (state_q)
      ST_IDLE:  if (!fifo_empty) state_d = ST_BEGIN;
      ST_BEGIN: if (out_ready) begin
        state_d = ST_ROW;
        batch_d = '0;
        gap_d   = '0;
      end
      ST_ROW: begin
        if (!fifo_empty) begin
          gap_d = '0;
          if (out_ready) begin
            batch_d = batch_q + BC_W'(1);
            if (batch_q + BC_W'(1) == BC_W'(BATCH)) state_d = ST_COMMIT;
          end
        // Group closes only on an empty buffer, so it always holds >= 1 row.
        end else if (flush || (gap_q + GC_W'(1) == GC_W'(TIMEOUT))) begin
          state_d = ST_COMMIT;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + GC_W'(1);
        end
      end
      ST_COMMIT: if (out_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ts_q    <= '0;
      drop_q  <= '0;
      batch_q <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      ts_q    <= ts_d;
      drop_q  <= drop_d;
      batch_q <= batch_d;
      gap_q   <= gap_d;
    end
  end

  // Outputs depend only on flops, so they hold until the handshake.
  always_comb begin
    out_valid = 1'b0;
    op        = OP_BEGIN;
    out_kind  = '0;
    out_addr  = '0;
    out_data  = '0;
    out_ts    = '0;
    unique case (state_q)
      ST_BEGIN: out_valid = 1'b1;
      ST_ROW: begin
        op = OP_ROW;
        if (!fifo_empty) begin
          out_valid = 1'b1;
          out_kind  = head.kind;
          out_addr  = head.addr;
          out_data  = head.data;
          out_ts    = head.ts;
        end
      end
      ST_COMMIT: begin
        out_valid = 1'b1;
        op        = OP_COMMIT;
      end
      default: out_valid = 1'b0;
    endcase
  end

  assign out_op   = op;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_sqlite_txn_recorder.sv
// Scoreboard bench: captures push expected rows, a negedge monitor pops and
// checks every handshake plus group framing, hold-while-stalled and counters.
module tb_sqlite_txn_recorder;
  import sqlite_rec_pkg::*;

  localparam int AW = 32, DW = 32, TW = 32;
  localparam int DEPTH = 16, BATCH = 8, TIMEOUT = 16;
  localparam int LW = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sqlite_txn_recorder_if #(.ADDR_W(AW), .DATA_W(DW), .TS_W(TW), .LVL_W(LW)) bus ();

  sqlite_txn_recorder #(
    .ADDR_W(AW), .DATA_W(DW), .TS_W(TW), .DEPTH(DEPTH), .BATCH(BATCH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (bus.in_valid),
    .in_kind    (bus.in_kind),
    .in_addr    (bus.in_addr),
    .in_data    (bus.in_data),
    .flush      (bus.flush),
    .out_valid  (bus.out_valid),
    .out_ready  (bus.out_ready),
    .out_op     (bus.out_op),
    .out_kind   (bus.out_kind),
    .out_addr   (bus.out_addr),
    .out_data   (bus.out_data),
    .out_ts     (bus.out_ts),
    .fifo_level (bus.fifo_level),
    .drop_cnt   (bus.drop_cnt)
  );

  typedef struct {
    logic [1:0]    k;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [TW-1:0] t;
  } exp_t;

  exp_t exp_q[$];
  int   grp_q[$];
  exp_t e_row;

  int checks = 0, failures = 0;
  int model_level = 0, model_drops = 0, prev_model_level = 0;
  logic [TW-1:0] model_ts = '0;
  int phase = 0, nrows = 0, cyc = 0, last_row_cyc = 0, last_commit_gap = -1;
  int first_cap_cyc = -1, begin_cyc = -1, row_hs_total = 0, accepted = 0;
  logic [TW-1:0] first_row_ts = '0;
  bit flush_seen = 0, got_first_row = 0;
  logic prev_vld = 0, prev_rdy = 0;
  logic [1:0] prev_op = '0, prev_k = '0;
  logic [AW-1:0] prev_a = '0;
  logic [DW-1:0] prev_d = '0;
  logic [TW-1:0] prev_t = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference model and monitor: everything is decided on the negedge
  // for the posedge that follows.
  always @(negedge clk) begin
    bit cap, pop;
    int gap;
    cap = 0;
    pop = 0;
    if (!rst_n) begin
      exp_q.delete();
      grp_q.delete();
      model_level = 0; model_drops = 0; prev_model_level = 0; model_ts = '0;
      phase = 0; nrows = 0; cyc = 0; last_row_cyc = 0; row_hs_total = 0; accepted = 0;
      first_cap_cyc = -1; begin_cyc = -1; flush_seen = 0; got_first_row = 0;
      prev_vld = 0; prev_rdy = 0;
    end else begin
      cyc++;
      chk("fifo_level", bus.fifo_level, model_level);
      chk("drop_cnt", bus.drop_cnt, model_drops);
      if (prev_vld && !prev_rdy) begin
        chk("hold_valid", bus.out_valid, 1);
        chk("hold_op", bus.out_op, prev_op);
        chk("hold_payload", (bus.out_kind == prev_k && bus.out_addr == prev_a &&
                             bus.out_data == prev_d && bus.out_ts == prev_t), 1);
      end
      if (bus.out_valid && bus.out_op == OP_BEGIN && !(prev_vld && prev_op == OP_BEGIN) && begin_cyc < 0)
        begin_cyc = cyc;
      if (bus.out_valid && bus.out_op == OP_COMMIT && !(prev_vld && prev_op == OP_COMMIT)) begin
        gap = cyc - last_row_cyc;
        last_commit_gap = gap;
        if (nrows == BATCH) chk("commit_gap_full", gap, 1);
        else begin
          chk("commit_on_empty", prev_model_level, 0);
          if (!flush_seen) chk("commit_gap_timeout", gap, TIMEOUT + 1);
        end
      end
      if (bus.flush && phase == 1 && model_level == 0) flush_seen = 1;

      if (bus.out_valid && bus.out_ready) begin
        case (bus.out_op)
          OP_BEGIN: begin
            chk("begin_framing", phase, 0);
            chk("begin_payload_zero", (bus.out_kind == 0 && bus.out_addr == 0 &&
                                       bus.out_data == 0 && bus.out_ts == 0), 1);
            phase = 1; nrows = 0; flush_seen = 0;
          end
          OP_ROW: begin
            chk("row_framing", phase, 1);
            chk("row_le_batch", nrows < BATCH, 1);
            chk("row_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
              e_row = exp_q.pop_front();
              chk("row_kind", bus.out_kind, e_row.k);
              chk("row_addr", bus.out_addr, e_row.a);
              chk("row_data", bus.out_data, e_row.d);
              chk("row_ts", bus.out_ts, e_row.t);
            end
            if (!got_first_row) begin first_row_ts = bus.out_ts; got_first_row = 1; end
            nrows++; row_hs_total++; last_row_cyc = cyc; flush_seen = 0; pop = 1;
          end
          OP_COMMIT: begin
            chk("commit_framing", phase, 1);
            chk("commit_group_nonempty", nrows >= 1, 1);
            chk("commit_payload_zero", (bus.out_kind == 0 && bus.out_addr == 0 &&
                                        bus.out_data == 0 && bus.out_ts == 0), 1);
            grp_q.push_back(nrows);
            phase = 0;
          end
          default: chk("op_legal", bus.out_op, 0);
        endcase
      end

      if (bus.in_valid) begin
        if (model_level < DEPTH) begin
          exp_q.push_back('{k: bus.in_kind, a: bus.in_addr, d: bus.in_data, t: model_ts});
          cap = 1;
          accepted++;
          if (first_cap_cyc < 0) first_cap_cyc = cyc;
        end else if (model_drops < 65535) model_drops++;
      end
      prev_model_level = model_level;
      model_level = model_level + int'(cap) - int'(pop);
      model_ts = model_ts + 1'b1;
      prev_vld = bus.out_valid; prev_rdy = bus.out_ready; prev_op = bus.out_op;
      prev_k = bus.out_kind; prev_a = bus.out_addr; prev_d = bus.out_data; prev_t = bus.out_ts;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.in_valid = 0;
    bus.flush = 0;
    rst_n = 0;
    repeat (3) step();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_op", bus.out_op, 0);
    chk("rst_payload", {bus.out_kind, bus.out_addr[15:0], bus.out_data[15:0], bus.out_ts[15:0]}, 0);
    chk("rst_fifo_level", bus.fifo_level, 0);
    chk("rst_drop_cnt", bus.drop_cnt, 0);
    rst_n = 1;
  endtask

  task automatic cap(input logic [1:0] k);
    bus.in_valid = 1;
    bus.in_kind = k;
    bus.in_addr = $urandom;
    bus.in_data = $urandom;
    step();
    bus.in_valid = 0;
  endtask

  task automatic drain(input string name, input int maxc);
    int n = 0;
    bus.out_ready = 1;
    while ((exp_q.size() != 0 || phase != 0 || model_level != 0) && n < maxc) begin
      step();
      n++;
    end
    chk(name, n < maxc, 1);
  endtask

  function automatic int grp(input int i);
    return (grp_q.size() > i) ? grp_q[i] : -1;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 0; bus.in_kind = 0; bus.in_addr = 0; bus.in_data = 0;
    bus.flush = 0; bus.out_ready = 0;

    // Three captures at ts 5,6,7, then timeout commit.
    do_reset();
    bus.out_ready = 1;
    repeat (5) step();
    cap(2'd0); cap(2'd1); cap(2'd2);
    drain("t1_drain", 100);
    chk("t1_groups", grp_q.size(), 1);
    chk("t1_rows", grp(0), 3);
    chk("t1_first_ts", first_row_ts, 5);
    chk("t1_begin_latency", begin_cyc - first_cap_cyc, 2);
    chk("t1_commit_gap", last_commit_gap, TIMEOUT + 1);

    // Ten back-to-back captures split into a full and a partial group.
    do_reset();
    bus.out_ready = 1;
    for (int i = 0; i < 10; i++) cap(2'(i));
    drain("t2_drain", 200);
    chk("t2_groups", grp_q.size(), 2);
    chk("t2_rows0", grp(0), BATCH);
    chk("t2_rows1", grp(1), 2);

    // Stalled logger: buffer fills, extra captures are dropped.
    do_reset();
    bus.out_ready = 0;
    for (int i = 0; i < 20; i++) cap(2'(i));
    step();
    chk("t3_level_full", bus.fifo_level, DEPTH);
    chk("t3_drops", bus.drop_cnt, 4);
    chk("t3_begin_held", {bus.out_valid, bus.out_op}, 3'b100);
    drain("t3_drain", 200);
    chk("t3_rows0", grp(0), BATCH);
    chk("t3_rows1", grp(1), BATCH);

    // Flush right after the second row closes the group without waiting.
    do_reset();
    bus.out_ready = 1;
    cap(2'd1); cap(2'd3);
    begin
      int n = 0;
      while (row_hs_total < 2 && n < 50) begin step(); n++; end
      chk("t4_rows_seen", row_hs_total, 2);
    end
    bus.flush = 1;
    step();
    bus.flush = 0;
    drain("t4_drain", 100);
    chk("t4_commit_gap", last_commit_gap, 2);
    chk("t4_rows", grp(0), 2);

    // Random captures with a randomly stalling logger.
    do_reset();
    begin
      int issued = 0;
      while (issued < 50) begin
        bus.out_ready = ($urandom_range(0, 99) < 65);
        if ($urandom_range(0, 1) == 1) begin
          bus.in_valid = 1;
          bus.in_kind = 2'($urandom_range(0, 3));
          bus.in_addr = $urandom;
          bus.in_data = $urandom;
          issued++;
        end else bus.in_valid = 0;
        step();
      end
      bus.in_valid = 0;
    end
    drain("t5_drain", 800);
    chk("t5_all_rows", row_hs_total, accepted);
    chk("t5_no_loss", accepted + model_drops, 50);

    // Reset while a group is open with five rows buffered.
    do_reset();
    bus.out_ready = 0;
    for (int i = 0; i < 5; i++) cap(2'(i));
    begin
      int n = 0;
      while (!(bus.out_valid && bus.out_op == OP_BEGIN) && n < 20) begin step(); n++; end
      chk("t6_begin_seen", n < 20, 1);
    end
    bus.out_ready = 1;
    step();
    bus.out_ready = 0;
    step();
    chk("t6_row_pending", {bus.out_valid, bus.out_op, bus.fifo_level}, {1'b1, 2'd1, LW'(5)});
    rst_n = 0;
    #1;
    chk("t6_rst_valid", bus.out_valid, 0);
    chk("t6_rst_level", bus.fifo_level, 0);
    repeat (2) step();
    rst_n = 1;
    bus.out_ready = 1;
    cap(2'd2); cap(2'd0);
    drain("t6_drain", 100);
    chk("t6_groups", grp_q.size(), 1);
    chk("t6_rows", grp(0), 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
